// File: rtl/upg_boot_ctrl.sv
// Boot-mode controller: debounces start_pg, sequences CPU run/programming/hold and counts uploaded words.
// Optional idle-write watchdog (ERR state, err_o) is built only when UPG_TIMEOUT_EN is defined.
module upg_boot_ctrl #(
    parameter int unsigned DEBOUNCE_CYCLES = 20000,
    parameter int unsigned HOLD_CYCLES     = 16,
    parameter int unsigned TIMEOUT_CYCLES  = 100000000
) (
    input  logic        fpga_clk,
    input  logic        fpga_rst,
    input  logic        start_pg,
    input  logic        upg_wen_i,
    input  logic [14:0] upg_adr_i,
    input  logic        upg_done_i,
    output logic        upg_rst_o,
    output logic        cpu_rst_o,
    output logic        rom_wen_o,
    output logic        ram_wen_o,
    output logic        prog_busy_o,
    output logic [13:0] rom_words_o,
    output logic [13:0] ram_words_o,
    output logic        err_o
);
    localparam logic [2:0] ST_RUN  = 3'd0;
    localparam logic [2:0] ST_ARM  = 3'd1;
    localparam logic [2:0] ST_PROG = 3'd2;
    localparam logic [2:0] ST_HOLD = 3'd3;
    localparam logic [2:0] ST_ERR  = 3'd4;

    localparam int unsigned DB_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int unsigned HD_W = $clog2(HOLD_CYCLES + 1);
    localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [HD_W-1:0] HD_LAST = HD_W'(HOLD_CYCLES - 1);

    logic [2:0]      state, state_nx;
    logic            start_s1, start_s2;
    logic            wen_s1, wen_s2, wen_s3;
    logic            done_s1, done_s2;
    logic [DB_W-1:0] db_cnt;
    logic [HD_W-1:0] hold_cnt;
    logic            wr_rise;
    logic            idle_expired;
    logic            unused_ok;

    assign wr_rise   = wen_s2 & ~wen_s3;
    assign rom_wen_o = (state == ST_PROG) & upg_wen_i & ~upg_adr_i[14];
    assign ram_wen_o = (state == ST_PROG) & upg_wen_i &  upg_adr_i[14];
    assign unused_ok = (^upg_adr_i[13:0]) ^ (TIMEOUT_CYCLES == 0);

    always_comb begin
        state_nx = state;
        case (state)
            ST_RUN:  if (start_s2) state_nx = ST_ARM;
            ST_ARM: begin
                if (!start_s2)              state_nx = ST_RUN;
                else if (db_cnt == DB_LAST) state_nx = ST_PROG;
            end
            ST_PROG: begin
                if (done_s2)           state_nx = ST_HOLD;
                else if (idle_expired) state_nx = ST_ERR;
            end
            ST_HOLD: if (hold_cnt == HD_LAST) state_nx = ST_RUN;
            ST_ERR:  if (start_s2) state_nx = ST_ARM;
            default: state_nx = ST_RUN;
        endcase
    end

    // Outputs are registered from the next state so they change on the same edge as the state.
    always_ff @(posedge fpga_clk) begin
        if (fpga_rst) begin
            state       <= ST_RUN;
            {start_s1, start_s2}    <= '0;
            {wen_s1, wen_s2, wen_s3} <= '0;
            {done_s1, done_s2}      <= '0;
            db_cnt      <= '0;
            hold_cnt    <= '0;
            cpu_rst_o   <= 1'b1;
            upg_rst_o   <= 1'b1;
            prog_busy_o <= 1'b0;
            rom_words_o <= '0;
            ram_words_o <= '0;
        end else begin
            start_s1    <= start_pg;
            start_s2    <= start_s1;
            wen_s1      <= upg_wen_i;
            wen_s2      <= wen_s1;
            wen_s3      <= wen_s2;
            done_s1     <= upg_done_i;
            done_s2     <= done_s1;
            state       <= state_nx;
            cpu_rst_o   <= (state_nx != ST_RUN);
            upg_rst_o   <= (state_nx != ST_PROG);
            prog_busy_o <= (state_nx == ST_ARM) || (state_nx == ST_PROG) || (state_nx == ST_HOLD);
            db_cnt      <= (state == ST_ARM  && state_nx == ST_ARM)  ? db_cnt + 1'b1   : '0;
            hold_cnt    <= (state == ST_HOLD && state_nx == ST_HOLD) ? hold_cnt + 1'b1 : '0;

            if (state == ST_ARM && state_nx == ST_PROG) begin
                rom_words_o <= '0;
                ram_words_o <= '0;
            end else if (state == ST_PROG && wr_rise) begin
                if (upg_adr_i[14]) begin
                    if (ram_words_o != '1) ram_words_o <= ram_words_o + 1'b1;
                end else begin
                    if (rom_words_o != '1) rom_words_o <= rom_words_o + 1'b1;
                end
            end
        end
    end

`ifdef UPG_TIMEOUT_EN
    localparam logic [26:0] IDLE_LAST = 27'(TIMEOUT_CYCLES - 1);
    logic [26:0] idle_cnt;

    assign idle_expired = (idle_cnt == IDLE_LAST) && !wr_rise;

    always_ff @(posedge fpga_clk) begin
        if (fpga_rst) begin
            idle_cnt <= '0;
            err_o    <= 1'b0;
        end else begin
            idle_cnt <= (state == ST_PROG && state_nx == ST_PROG && !wr_rise) ? idle_cnt + 1'b1 : '0;
            err_o    <= (state_nx == ST_ERR);
        end
    end
`else
    assign idle_expired = 1'b0;
    assign err_o        = 1'b0;
`endif

endmodule

// File: tb/tb_upg_boot_ctrl.sv
// Directed self-checking bench for upg_boot_ctrl with DEBOUNCE_CYCLES=8, HOLD_CYCLES=4.
// The watchdog scenario is compiled in only when UPG_TIMEOUT_EN is defined.
module tb_upg_boot_ctrl;
    logic        fpga_clk = 1'b0;
    logic        fpga_rst;
    logic        start_pg;
    logic        upg_wen_i;
    logic [14:0] upg_adr_i;
    logic        upg_done_i;
    logic        upg_rst_o, cpu_rst_o, rom_wen_o, ram_wen_o, prog_busy_o, err_o;
    logic [13:0] rom_words_o, ram_words_o;

    int errors = 0;
    int checks = 0;
    int rom_pulses = 0;
    int ram_pulses = 0;

    upg_boot_ctrl #(
        .DEBOUNCE_CYCLES(8),
        .HOLD_CYCLES    (4),
        .TIMEOUT_CYCLES (50)
    ) dut (
        .fpga_clk   (fpga_clk),
        .fpga_rst   (fpga_rst),
        .start_pg   (start_pg),
        .upg_wen_i  (upg_wen_i),
        .upg_adr_i  (upg_adr_i),
        .upg_done_i (upg_done_i),
        .upg_rst_o  (upg_rst_o),
        .cpu_rst_o  (cpu_rst_o),
        .rom_wen_o  (rom_wen_o),
        .ram_wen_o  (ram_wen_o),
        .prog_busy_o(prog_busy_o),
        .rom_words_o(rom_words_o),
        .ram_words_o(ram_words_o),
        .err_o      (err_o)
    );

    always #5 fpga_clk = ~fpga_clk;

    always @(posedge fpga_clk) begin
        if (rom_wen_o === 1'b1) rom_pulses <= rom_pulses + 1;
        if (ram_wen_o === 1'b1) ram_pulses <= ram_pulses + 1;
    end

    // start_pg held through sync + debounce; PROG is entered on the 11th edge.
    task automatic press_to_prog();
        start_pg = 1'b1;
        repeat (11) @(negedge fpga_clk);
        start_pg = 1'b0;
    endtask

    task automatic test_reset();
        fpga_rst = 1'b1; start_pg = 1'b0; upg_wen_i = 1'b0; upg_done_i = 1'b0; upg_adr_i = '0;
        repeat (3) @(negedge fpga_clk);
        checks++; if (cpu_rst_o !== 1'b1) begin errors++; $display("FAIL reset_cpu_rst: got %b want 1", cpu_rst_o); end
        checks++; if (upg_rst_o !== 1'b1) begin errors++; $display("FAIL reset_upg_rst: got %b want 1", upg_rst_o); end
        checks++; if (prog_busy_o !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", prog_busy_o); end
        checks++; if (err_o !== 1'b0) begin errors++; $display("FAIL reset_err: got %b want 0", err_o); end
        checks++; if (rom_words_o !== 14'd0 || ram_words_o !== 14'd0) begin
            errors++; $display("FAIL reset_words: got rom=%0d ram=%0d want 0 0", rom_words_o, ram_words_o); end
        fpga_rst = 1'b0;
        @(negedge fpga_clk);
        checks++; if (cpu_rst_o !== 1'b0) begin errors++; $display("FAIL release_cpu_rst: got %b want 0", cpu_rst_o); end
        checks++; if (upg_rst_o !== 1'b1) begin errors++; $display("FAIL release_upg_rst: got %b want 1", upg_rst_o); end
        upg_adr_i = 15'h4000; upg_wen_i = 1'b1; #1;
        checks++; if (rom_wen_o !== 1'b0 || ram_wen_o !== 1'b0) begin
            errors++; $display("FAIL run_wen_gated: got rom=%b ram=%b want 0 0", rom_wen_o, ram_wen_o); end
        @(negedge fpga_clk); upg_wen_i = 1'b0;
        repeat (3) @(negedge fpga_clk);
        checks++; if (ram_words_o !== 14'd0) begin errors++; $display("FAIL run_no_count: got %0d want 0", ram_words_o); end
        upg_adr_i = '0;
    endtask

    task automatic test_glitch();
        logic saw_low;
        saw_low = 1'b0;
        start_pg = 1'b1;
        for (int i = 1; i <= 5; i++) begin
            @(negedge fpga_clk);
            if (upg_rst_o !== 1'b1) saw_low = 1'b1;
            if (i == 3) begin
                checks++; if (prog_busy_o !== 1'b1 || cpu_rst_o !== 1'b1) begin
                    errors++; $display("FAIL glitch_arm: got busy=%b cpu_rst=%b want 1 1", prog_busy_o, cpu_rst_o); end
            end
        end
        start_pg = 1'b0;
        for (int i = 1; i <= 8; i++) begin
            @(negedge fpga_clk);
            if (upg_rst_o !== 1'b1) saw_low = 1'b1;
        end
        checks++; if (saw_low !== 1'b0) begin errors++; $display("FAIL glitch_upg_rst: got low=%b want 0", saw_low); end
        checks++; if (prog_busy_o !== 1'b0 || cpu_rst_o !== 1'b0) begin
            errors++; $display("FAIL glitch_back_run: got busy=%b cpu_rst=%b want 0 0", prog_busy_o, cpu_rst_o); end
    endtask

    task automatic test_upload();
        start_pg = 1'b1;
        for (int j = 1; j <= 11; j++) begin
            @(negedge fpga_clk);
            if (j == 10) begin
                checks++; if (upg_rst_o !== 1'b1) begin errors++; $display("FAIL upload_edge10_upg_rst: got %b want 1", upg_rst_o); end
            end
            if (j == 11) begin
                checks++; if (upg_rst_o !== 1'b0 || prog_busy_o !== 1'b1) begin
                    errors++; $display("FAIL upload_edge11_prog: got upg_rst=%b busy=%b want 0 1", upg_rst_o, prog_busy_o); end
            end
        end
        start_pg = 1'b0;
        rom_pulses = 0; ram_pulses = 0;
        for (int k = 0; k < 5; k++) begin
            upg_adr_i = (k < 3) ? 15'(k) : 15'(16384 + k - 3);
            upg_wen_i = 1'b1; #1;
            checks++; if (rom_wen_o !== (k < 3) || ram_wen_o !== (k >= 3)) begin
                errors++; $display("FAIL upload_wen_steer%0d: got rom=%b ram=%b want %b %b", k, rom_wen_o, ram_wen_o, k < 3, k >= 3); end
            @(negedge fpga_clk); upg_wen_i = 1'b0;
            repeat (3) @(negedge fpga_clk);
        end
        checks++; if (rom_pulses != 3 || ram_pulses != 2) begin
            errors++; $display("FAIL upload_pulses: got rom=%0d ram=%0d want 3 2", rom_pulses, ram_pulses); end
        checks++; if (rom_words_o !== 14'd3 || ram_words_o !== 14'd2) begin
            errors++; $display("FAIL upload_words: got rom=%0d ram=%0d want 3 2", rom_words_o, ram_words_o); end
        upg_done_i = 1'b1;
        for (int j = 1; j <= 7; j++) begin
            @(negedge fpga_clk);
            if (j == 3) begin
                checks++; if (upg_rst_o !== 1'b1 || prog_busy_o !== 1'b1) begin
                    errors++; $display("FAIL upload_hold: got upg_rst=%b busy=%b want 1 1", upg_rst_o, prog_busy_o); end
            end
            if (j == 6) begin
                checks++; if (cpu_rst_o !== 1'b1) begin errors++; $display("FAIL upload_done6_cpu_rst: got %b want 1", cpu_rst_o); end
            end
            if (j == 7) begin
                checks++; if (cpu_rst_o !== 1'b0 || prog_busy_o !== 1'b0) begin
                    errors++; $display("FAIL upload_done7_release: got cpu_rst=%b busy=%b want 0 0", cpu_rst_o, prog_busy_o); end
            end
        end
        upg_done_i = 1'b0;
        repeat (3) @(negedge fpga_clk);
        checks++; if (rom_words_o !== 14'd3 || ram_words_o !== 14'd2) begin
            errors++; $display("FAIL upload_words_kept: got rom=%0d ram=%0d want 3 2", rom_words_o, ram_words_o); end
    endtask

    task automatic test_write_with_done();
        press_to_prog();
        upg_adr_i = 15'h4005; upg_wen_i = 1'b1; upg_done_i = 1'b1;
        for (int j = 1; j <= 7; j++) begin
            @(negedge fpga_clk);
            if (j == 1) upg_wen_i = 1'b0;
            if (j == 6) begin
                checks++; if (cpu_rst_o !== 1'b1) begin errors++; $display("FAIL wdone_hold_cpu_rst: got %b want 1", cpu_rst_o); end
            end
        end
        upg_done_i = 1'b0;
        checks++; if (cpu_rst_o !== 1'b0) begin errors++; $display("FAIL wdone_release: got %b want 0", cpu_rst_o); end
        checks++; if (ram_words_o !== 14'd1 || rom_words_o !== 14'd0) begin
            errors++; $display("FAIL wdone_words: got rom=%0d ram=%0d want 0 1", rom_words_o, ram_words_o); end
        upg_adr_i = '0;
        repeat (3) @(negedge fpga_clk);
    endtask

    task automatic test_reset_mid();
        press_to_prog();
        upg_adr_i = 15'h0001; upg_wen_i = 1'b1;
        @(negedge fpga_clk); upg_wen_i = 1'b0;
        repeat (3) @(negedge fpga_clk);
        checks++; if (rom_words_o !== 14'd1) begin errors++; $display("FAIL midrst_pre_words: got %0d want 1", rom_words_o); end
        fpga_rst = 1'b1;
        @(negedge fpga_clk);
        checks++; if (upg_rst_o !== 1'b1 || prog_busy_o !== 1'b0) begin
            errors++; $display("FAIL midrst_upg_rst: got upg_rst=%b busy=%b want 1 0", upg_rst_o, prog_busy_o); end
        checks++; if (rom_words_o !== 14'd0 || ram_words_o !== 14'd0) begin
            errors++; $display("FAIL midrst_words: got rom=%0d ram=%0d want 0 0", rom_words_o, ram_words_o); end
        fpga_rst = 1'b0;
        @(negedge fpga_clk);
        checks++; if (cpu_rst_o !== 1'b0 || upg_rst_o !== 1'b1) begin
            errors++; $display("FAIL midrst_run: got cpu_rst=%b upg_rst=%b want 0 1", cpu_rst_o, upg_rst_o); end
        upg_adr_i = '0;
    endtask

    task automatic test_saturation();
        press_to_prog();
        upg_adr_i = 15'h0000;
        for (int n = 0; n < 16385; n++) begin
            upg_wen_i = 1'b1;
            @(negedge fpga_clk);
            upg_wen_i = 1'b0;
            @(negedge fpga_clk);
        end
        repeat (3) @(negedge fpga_clk);
        checks++; if (rom_words_o !== 14'd16383 || ram_words_o !== 14'd0) begin
            errors++; $display("FAIL sat_words: got rom=%0d ram=%0d want 16383 0", rom_words_o, ram_words_o); end
        upg_done_i = 1'b1;
        repeat (8) @(negedge fpga_clk);
        upg_done_i = 1'b0;
        repeat (3) @(negedge fpga_clk);
        checks++; if (cpu_rst_o !== 1'b0 || rom_words_o !== 14'd16383) begin
            errors++; $display("FAIL sat_after_done: got cpu_rst=%b rom=%0d want 0 16383", cpu_rst_o, rom_words_o); end
    endtask

`ifdef UPG_TIMEOUT_EN
    task automatic test_watchdog();
        press_to_prog();
        for (int j = 1; j <= 50; j++) begin
            @(negedge fpga_clk);
            if (j == 49) begin
                checks++; if (err_o !== 1'b0) begin errors++; $display("FAIL wdog_early: got %b want 0", err_o); end
            end
        end
        checks++; if (err_o !== 1'b1 || cpu_rst_o !== 1'b1 || upg_rst_o !== 1'b1) begin
            errors++; $display("FAIL wdog_err: got err=%b cpu_rst=%b upg_rst=%b want 1 1 1", err_o, cpu_rst_o, upg_rst_o); end
        start_pg = 1'b1;
        repeat (3) @(negedge fpga_clk);
        checks++; if (err_o !== 1'b0 || prog_busy_o !== 1'b1) begin
            errors++; $display("FAIL wdog_rearm: got err=%b busy=%b want 0 1", err_o, prog_busy_o); end
        start_pg = 1'b0;
        repeat (6) @(negedge fpga_clk);
    endtask
`endif

    initial begin
        test_reset();
        test_glitch();
        test_upload();
        test_write_with_done();
        test_reset_mid();
        test_saturation();
`ifdef UPG_TIMEOUT_EN
        test_watchdog();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
